// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: sequencer states, opcodes, ALU select codes and IR field layout.
// Used by the control sequencer, the ALU and any later instruction decoder.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  localparam int IR_OP_MSB = 31;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;
  localparam int IDXW      = 4;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] SEL_ADD = 4'b0001;
  localparam logic [3:0] SEL_SUB = 4'b0010;
  localparam logic [3:0] SEL_SHR = 4'b0011;
  localparam logic [3:0] SEL_SHL = 4'b0100;
  localparam logic [3:0] SEL_ROR = 4'b0101;
  localparam logic [3:0] SEL_AND = 4'b0110;
  localparam logic [3:0] SEL_OR  = 4'b0111;
  localparam logic [3:0] SEL_ROL = 4'b1000;
  localparam logic [3:0] SEL_MUL = 4'b1001;
  localparam logic [3:0] SEL_DIV = 4'b1010;
  localparam logic [3:0] SEL_NEG = 4'b1011;
  localparam logic [3:0] SEL_NOT = 4'b1100;

  typedef struct packed {
    logic       legal;   // executes through T3..T5 (halt is handled separately)
    logic       muldiv;  // needs T6 for the high half
    logic       unary;   // second operand comes from rb, not rc
    logic [3:0] sel;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [4:0] op);
    op_info_t d;
    d = '{legal: 1'b1, muldiv: 1'b0, unary: 1'b0, sel: 4'b0000};
    case (op)
      OP_ADD:  d.sel = SEL_ADD;
      OP_SUB:  d.sel = SEL_SUB;
      OP_AND:  d.sel = SEL_AND;
      OP_OR:   d.sel = SEL_OR;
      OP_SHR:  d.sel = SEL_SHR;
      OP_SHL:  d.sel = SEL_SHL;
      OP_ROR:  d.sel = SEL_ROR;
      OP_ROL:  d.sel = SEL_ROL;
      OP_MUL:  begin d.sel = SEL_MUL; d.muldiv = 1'b1; end
      OP_DIV:  begin d.sel = SEL_DIV; d.muldiv = 1'b1; end
      OP_NEG:  begin d.sel = SEL_NEG; d.unary = 1'b1; end
      OP_NOT:  begin d.sel = SEL_NOT; d.unary = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register index to one-hot select, gated by an enable.
module reg_select_decoder #(
  parameter int NUM_REGS = 16,
  parameter int IDXW     = 4
) (
  input  logic                en,
  input  logic [IDXW-1:0]     idx,
  output logic [NUM_REGS-1:0] onehot
);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bit
    assign onehot[g] = en && (idx == IDXW'(g));
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit for the single-bus datapath: fetch T0..T2, execute T3..T6.
// Strobes are decoded from the present state and IR fields; the datapath samples them next edge.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5,
  parameter int SELW     = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCin,
  output logic                PCout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                HIin,
  output logic                HIout,
  output logic                LOin,
  output logic                LOout,
  output logic                IncPC,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                Read,
  output logic [SELW-1:0]     ALUselect,
  output logic                halted,
  output logic                illegal,
  output logic [3:0]          state_dbg
);

  state_e          state;
  logic            t1_seen;
  logic [OPW-1:0]  opcode;
  logic [IDXW-1:0] ra, rb, rc, rout_idx;
  logic            rin_en, rout_en;
  op_info_t        info;
  logic            unused_ir;

  assign opcode    = ir[IR_OP_MSB -: OPW];
  assign ra        = ir[IR_RA_LSB +: IDXW];
  assign rb        = ir[IR_RB_LSB +: IDXW];
  assign rc        = ir[IR_RC_LSB +: IDXW];
  assign unused_ir = ^ir[IR_RC_LSB-1:0];
  assign info      = decode_op(opcode);
  assign state_dbg = state;

  // HI/LO bus drives are reserved for move-from-HI/LO and tied low
  assign HIout = 1'b0;
  assign LOout = 1'b0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_IDLE;
      t1_seen <= 1'b0;
      illegal <= 1'b0;
      halted  <= 1'b0;
    end else begin
      t1_seen <= (state == S_T1);
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   if (mem_ready) state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3: begin
          if (opcode == OP_HALT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!info.legal) begin
            state   <= S_IDLE;
            illegal <= 1'b1;
          end else begin
            state <= S_T4;
          end
        end
        S_T4:   state <= S_T5;
        S_T5:   state <= info.muldiv ? S_T6 : S_IDLE;
        S_T6:   state <= S_IDLE;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    {PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout} = '0;
    {HIin, LOin, IncPC, Zhighout, Zlowout, Read}        = '0;
    ALUselect = '0;
    rin_en    = 1'b0;
    rout_en   = 1'b0;
    rout_idx  = rb;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      // PC loads once per fetch even if the memory read stalls in T1
      S_T1: begin Zlowout = 1'b1; PCin = !t1_seen; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: if (info.legal) begin rout_en = 1'b1; Yin = 1'b1; end
      S_T4: begin
        ALUselect = SELW'(info.sel);
        Zin       = 1'b1;
        rout_en   = 1'b1;
        rout_idx  = info.unary ? rb : rc;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (info.muldiv) LOin = 1'b1;
        else             rin_en = 1'b1;
      end
      S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS), .IDXW(IDXW)) u_rin_dec (
    .en(rin_en), .idx(ra), .onehot(Rin)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS), .IDXW(IDXW)) u_rout_dec (
    .en(rout_en), .idx(rout_idx), .onehot(Rout)
  );

  a_one_bus_driver: assert property (@(posedge clock) disable iff (!clear)
    $onehot0({Rout, PCout, MDRout, Zlowout, Zhighout, HIout, LOout}));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-state strobe checks, stalls, mul, illegal, halt, reset.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic [15:0] Rin, Rout;
  logic        PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout;
  logic        HIin, HIout, LOin, LOout, IncPC, Zhighout, Zlowout, Read;
  logic [3:0]  ALUselect, state_dbg;
  logic        halted, illegal;
  logic [15:0] strb;

  localparam logic [15:0] M_PCIN  = 16'h8000, M_PCOUT = 16'h4000, M_IRIN  = 16'h2000;
  localparam logic [15:0] M_YIN   = 16'h1000, M_ZIN   = 16'h0800, M_MARIN = 16'h0400;
  localparam logic [15:0] M_MDRIN = 16'h0200, M_MDROUT= 16'h0100, M_HIIN  = 16'h0080;
  localparam logic [15:0] M_LOIN  = 16'h0020, M_INCPC = 16'h0008, M_ZHI   = 16'h0004;
  localparam logic [15:0] M_ZLO   = 16'h0002, M_READ  = 16'h0001;
  localparam logic [15:0] F_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [15:0] F_T1 = M_ZLO | M_READ | M_MDRIN;
  localparam logic [15:0] F_T2 = M_MDROUT | M_IRIN;

  assign strb = {PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout,
                 HIin, HIout, LOin, LOout, IncPC, Zhighout, Zlowout, Read};

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin),
    .HIout(HIout), .LOin(LOin), .LOout(LOout), .IncPC(IncPC), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .Read(Read), .ALUselect(ALUselect), .halted(halted),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_st(input string tag, input logic [3:0] st, input logic [15:0] sb,
                        input logic [15:0] ri, input logic [15:0] ro, input logic [3:0] sel);
    chk({tag, ".state"}, 32'(state_dbg), 32'(st));
    chk({tag, ".strb"},  32'(strb),      32'(sb));
    chk({tag, ".rin"},   32'(Rin),       32'(ri));
    chk({tag, ".rout"},  32'(Rout),      32'(ro));
    chk({tag, ".sel"},   32'(ALUselect), 32'(sel));
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // one ALU instruction launched by a single-cycle run pulse; ends parked in IDLE
  task automatic run_alu(input string tag, input logic [31:0] iv, input logic [15:0] ro3,
                         input logic [15:0] ro4, input logic [3:0] sel, input logic [15:0] ri);
    ir = iv; run = 1'b1;
    cyc(); chk_st({tag, ".T0"}, 4'd1, F_T0, '0, '0, '0);
    run = 1'b0;
    cyc(); chk_st({tag, ".T1"}, 4'd2, F_T1 | M_PCIN, '0, '0, '0);
    cyc(); chk_st({tag, ".T2"}, 4'd3, F_T2, '0, '0, '0);
    cyc(); chk_st({tag, ".T3"}, 4'd4, M_YIN, '0, ro3, '0);
    cyc(); chk_st({tag, ".T4"}, 4'd5, M_ZIN, '0, ro4, sel);
    cyc(); chk_st({tag, ".T5"}, 4'd6, M_ZLO, ri, '0, '0);
    cyc(); chk_st({tag, ".idle"}, 4'd0, '0, '0, '0, '0);
    cyc(); chk_st({tag, ".park"}, 4'd0, '0, '0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    clear = 1'b0; run = 1'b0; mem_ready = 1'b1; ir = '0;
    #7;
    chk_st("reset", 4'd0, '0, '0, '0, '0);
    chk("reset.illegal", 32'(illegal), 0);
    chk("reset.halted",  32'(halted),  0);
    cyc(); clear = 1'b1;

    run_alu("and",    32'h28918000, 16'h0004, 16'h0008, 4'b0110, 16'h0002);
    run_alu("add_r0", 32'h18780000, 16'h8000, 16'h0001, 4'b0001, 16'h0001);
    run_alu("neg",    32'h89180000, 16'h0008, 16'h0008, 4'b1011, 16'h0004);

    // three stalled T1 cycles with run held: T0-to-T0 spans 10 cycles
    ir = 32'h28918000; run = 1'b1; mem_ready = 1'b0;
    cyc(); chk_st("stall.T0", 4'd1, F_T0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_st($sformatf("stall.T1_%0d", i), 4'd2, F_T1 | ((i == 0) ? M_PCIN : 16'h0), '0, '0, '0);
      if (i == 3) mem_ready = 1'b1;
    end
    cyc(); chk_st("stall.T2", 4'd3, F_T2, '0, '0, '0);
    n = 0;
    while (state_dbg != 4'd1 && n < 20) begin cyc(); n++; end
    chk("stall.cycles", 32'(5 + n), 10);
    run = 1'b0;
    n = 0;
    while (state_dbg != 4'd0 && n < 20) begin cyc(); n++; end
    chk("stall.tail", 32'(n), 6);

    // mul: T5 writes LO, T6 writes HI, no Rin; 8 cycles with run held
    ir = 32'h7B300000; run = 1'b1;
    cyc(); chk_st("mul.T0", 4'd1, F_T0, '0, '0, '0);
    cyc(); chk_st("mul.T1", 4'd2, F_T1 | M_PCIN, '0, '0, '0);
    cyc(); chk_st("mul.T2", 4'd3, F_T2, '0, '0, '0);
    cyc(); chk_st("mul.T3", 4'd4, M_YIN, '0, 16'h0040, '0);
    cyc(); chk_st("mul.T4", 4'd5, M_ZIN, '0, 16'h0001, 4'b1001);
    cyc(); chk_st("mul.T5", 4'd6, M_ZLO | M_LOIN, '0, '0, '0);
    cyc(); chk_st("mul.T6", 4'd7, M_ZHI | M_HIIN, '0, '0, '0);
    cyc(); chk_st("mul.idle", 4'd0, '0, '0, '0, '0);
    cyc(); chk("mul.8cyc", 32'(state_dbg), 1);

    // abort the next mul in T4 with a one-cycle clear pulse
    run = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("rst.preT4", 32'(state_dbg), 5);
    clear = 1'b0;
    #1;
    chk_st("rst.midT4", 4'd0, '0, '0, '0, '0);
    chk("rst.illegal", 32'(illegal), 0);
    cyc(); clear = 1'b1;
    cyc(); chk_st("rst.park", 4'd0, '0, '0, '0, '0);

    // undefined opcode: flagged after T3, back to IDLE, no register write
    ir = 32'hF8000000; run = 1'b1;
    cyc(); run = 1'b0;
    cyc(); cyc(); cyc();
    chk_st("ill.T3", 4'd4, '0, '0, '0, '0);
    chk("ill.pre", 32'(illegal), 0);
    cyc(); chk_st("ill.idle", 4'd0, '0, '0, '0, '0);
    chk("ill.flag", 32'(illegal), 1);

    // halt: absorbing despite run held
    ir = 32'hD8000000; run = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk_st("halt.T3", 4'd4, '0, '0, '0, '0);
    chk("halt.pre", 32'(halted), 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk($sformatf("halt.state_%0d", i), 32'(state_dbg), 8);
      chk($sformatf("halt.strb_%0d", i), 32'(strb), 0);
      chk($sformatf("halt.flag_%0d", i), 32'(halted), 1);
    end
    chk("halt.ill_sticky", 32'(illegal), 1);
    clear = 1'b0;
    #1;
    chk("clr.state",   32'(state_dbg), 0);
    chk("clr.halted",  32'(halted),    0);
    chk("clr.illegal", 32'(illegal),   0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
